// File: rtl/ts_log_pkg.sv
// ---------------------------------------------------------------------------
// ts_log_pkg
// Shared types and constants for the timestamp-event logging path.
//   TS_ID_W    : width of an event id
//   TS_W       : width of a timestamp / delta field
//   ts_event_t : one event record {id, start_ts, end_ts, delta}
// ---------------------------------------------------------------------------
package ts_log_pkg;

  localparam int TS_ID_W = 16;
  localparam int TS_W    = 64;

  typedef struct packed {
    logic [TS_ID_W-1:0] id;
    logic [TS_W-1:0]    start_ts;
    logic [TS_W-1:0]    end_ts;
    logic [TS_W-1:0]    delta;
  } ts_event_t;

endpackage : ts_log_pkg

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick. The pointer register is owned by
// the caller; this block only chooses the first requester at or after ptr.
// Ports:
//   req     in  N   request vector
//   ptr     in  PW  search start index (0..N-1)
//   gnt     out N   one-hot grant (all zero when no request)
//   gnt_idx out PW  index of the granted requester (0 when none)
//   any     out 1   at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx,
  output logic          any
);

  logic [PW:0]   w_sum;
  logic [PW-1:0] w_idx;

  // Walk ptr, ptr+1, ... (mod N); the first requester seen wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    w_sum   = '0;
    w_idx   = '0;
    for (int k = 0; k < N; k++) begin
      w_sum = {1'b0, ptr} + (PW+1)'(k);
      if (w_sum >= (PW+1)'(N)) begin
        w_sum = w_sum - (PW+1)'(N);
      end
      w_idx = w_sum[PW-1:0];
      if (!any && req[w_idx]) begin
        any        = 1'b1;
        gnt[w_idx] = 1'b1;
        gnt_idx    = w_idx;
      end
    end
  end

endmodule : rr_arbiter

// File: rtl/ts_event_arbiter.sv
// ---------------------------------------------------------------------------
// ts_event_arbiter
// Shares one timestamp-event logger between N_SRC producers. One producer
// is granted per accepted event (round robin) and its event is registered
// into a single valid/ready output stage.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   en              1: accept new events; 0: hold off sources (output drains)
//   in_valid/ready  per-source handshake (ready is one-hot or zero)
//   in_id/start_ts/end_ts/delta  packed per-source event fields
//   out_valid/ready registered event handshake toward the logger
//   out_id/start_ts/end_ts/delta held event (id optionally tagged)
//   out_src         source index of the held event
//   evt_cnt         wrapping accepted-event counter per source
// ---------------------------------------------------------------------------
module ts_event_arbiter
  import ts_log_pkg::*;
#(
  parameter  int N_SRC   = 4,
  parameter  int TAG_SRC = 1,
  parameter  int CNT_W   = 32,
  localparam int SW      = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [N_SRC-1:0]         in_valid,
  output logic [N_SRC-1:0]         in_ready,
  input  logic [N_SRC*TS_ID_W-1:0] in_id,
  input  logic [N_SRC*TS_W-1:0]    in_start_ts,
  input  logic [N_SRC*TS_W-1:0]    in_end_ts,
  input  logic [N_SRC*TS_W-1:0]    in_delta,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [TS_ID_W-1:0]       out_id,
  output logic [TS_W-1:0]          out_start_ts,
  output logic [TS_W-1:0]          out_end_ts,
  output logic [TS_W-1:0]          out_delta,
  output logic [SW-1:0]            out_src,
  output logic [N_SRC*CNT_W-1:0]   evt_cnt
);

  ts_event_t          w_src_evt [N_SRC];
  ts_event_t          w_sel_evt;
  logic [TS_ID_W-1:0] w_tag_id;
  logic [N_SRC-1:0]   w_gnt;
  logic [SW-1:0]      w_gnt_idx;
  logic               w_any;
  logic               w_load;
  logic [SW-1:0]      w_ptr_next;

  logic               r_out_valid;
  ts_event_t          r_out_evt;
  logic [SW-1:0]      r_out_src;
  logic [SW-1:0]      r_rr_ptr;
  logic [CNT_W-1:0]   r_evt_cnt [N_SRC];

  // Unpack the flat per-source buses into event records.
  for (genvar gi = 0; gi < N_SRC; gi++) begin : g_unpack
    assign w_src_evt[gi].id       = in_id[gi*TS_ID_W +: TS_ID_W];
    assign w_src_evt[gi].start_ts = in_start_ts[gi*TS_W +: TS_W];
    assign w_src_evt[gi].end_ts   = in_end_ts[gi*TS_W +: TS_W];
    assign w_src_evt[gi].delta    = in_delta[gi*TS_W +: TS_W];
  end

  rr_arbiter #(
    .N  (N_SRC),
    .PW (SW)
  ) u_rr (
    .req     (in_valid),
    .ptr     (r_rr_ptr),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx),
    .any     (w_any)
  );

  // Accept when enabled, the output slot is free or draining this cycle,
  // and somebody is asking. Reset blocks any handshake on the reset cycle.
  assign w_load   = !rst && en && (!r_out_valid || out_ready) && w_any;
  assign in_ready = w_load ? w_gnt : '0;

  assign w_sel_evt = w_src_evt[w_gnt_idx];

  if (TAG_SRC != 0) begin : g_tag
    // Top SW bits of the id carry the granted source index.
    assign w_tag_id = {w_gnt_idx, w_sel_evt.id[TS_ID_W-SW-1:0]};
  end else begin : g_no_tag
    assign w_tag_id = w_sel_evt.id;
  end

  assign w_ptr_next = (w_gnt_idx == SW'(N_SRC - 1)) ? '0 : w_gnt_idx + SW'(1);

  // Output register stage. A simultaneous drain and accept simply
  // overwrites the slot, giving one event per clock with no bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_evt   <= '0;
      r_out_src   <= '0;
      r_rr_ptr    <= '0;
    end else if (w_load) begin
      r_out_valid        <= 1'b1;
      r_out_evt.id       <= w_tag_id;
      r_out_evt.start_ts <= w_sel_evt.start_ts;
      r_out_evt.end_ts   <= w_sel_evt.end_ts;
      r_out_evt.delta    <= w_sel_evt.delta;
      r_out_src          <= w_gnt_idx;
      r_rr_ptr           <= w_ptr_next;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  for (genvar gi = 0; gi < N_SRC; gi++) begin : g_cnt
    always_ff @(posedge clk) begin
      if (rst) begin
        r_evt_cnt[gi] <= '0;
      end else if (w_load && w_gnt[gi]) begin
        r_evt_cnt[gi] <= r_evt_cnt[gi] + CNT_W'(1);
      end
    end
    assign evt_cnt[gi*CNT_W +: CNT_W] = r_evt_cnt[gi];
  end

  assign out_valid    = r_out_valid;
  assign out_id       = r_out_evt.id;
  assign out_start_ts = r_out_evt.start_ts;
  assign out_end_ts   = r_out_evt.end_ts;
  assign out_delta    = r_out_evt.delta;
  assign out_src      = r_out_src;

endmodule : ts_event_arbiter
